// File: rtl/card_flip_pkg.sv
// card_flip_pkg: shared Card-Flip constants and FSM state encoding
package card_flip_pkg;
  localparam int N_CARDS = 16;
  localparam int N_PAIRS = 8;
  localparam int VAL_W = 3;
  localparam int IDX_W = 4;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FIRST     = 3'd1,
    SECOND    = 3'd2,
    COMPARE   = 3'd3,
    SHOW_MISS = 3'd4,
    DONE      = 3'd5
  } state_t;
endpackage

// File: rtl/card_flip_ctrl_hold_timer.sv
// hold_timer: loadable down-counter (clk, reset, load -> zero), loads HOLD_CYCLES-1 and stops at 0
module hold_timer #(
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic zero
);
  localparam int W = $clog2(HOLD_CYCLES + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else cnt <= load ? W'(HOLD_CYCLES - 1) : (cnt != '0 ? cnt - 1'b1 : cnt);
  assign zero = cnt == '0;
endmodule

// File: rtl/card_flip_ctrl.sv
// card_flip_ctrl: memory-match game FSM (clk, reset, start, layout, sel_valid/sel_idx -> game_start, game_end, face_up, matched, pairs_found, moves, state)
module card_flip_ctrl
  import card_flip_pkg::*;
#(
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [N_CARDS*VAL_W-1:0] layout,
  input  logic                     sel_valid,
  input  logic [IDX_W-1:0]         sel_idx,
  output logic                     game_start,
  output logic                     game_end,
  output logic [N_CARDS-1:0]       face_up,
  output logic [N_CARDS-1:0]       matched,
  output logic [3:0]               pairs_found,
  output logic [7:0]               moves,
  output logic [2:0]               state
);
  state_t st, st_d;
  logic [N_CARDS-1:0][VAL_W-1:0] vals, vals_d;
  logic [IDX_W-1:0] idx_a, idx_b, a_d, b_d;
  logic [N_CARDS-1:0] face_d, matched_d;
  logic [3:0] pairs_d;
  logic [7:0] moves_d;
  logic gs_d, ge_d, load, zero, legal;
  hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold (
    .clk  (clk),
    .reset(reset),
    .load (load),
    .zero (zero)
  );
  assign legal = sel_valid && !face_up[sel_idx];
  assign state = st;
  always_comb begin
    st_d = st;
    vals_d = vals;
    a_d = idx_a;
    b_d = idx_b;
    face_d = face_up;
    matched_d = matched;
    pairs_d = pairs_found;
    moves_d = moves;
    gs_d = 1'b0;
    ge_d = 1'b0;
    load = 1'b0;
    case (st)
      IDLE, DONE: if (start) begin
        vals_d = layout;
        face_d = '0;
        matched_d = '0;
        pairs_d = '0;
        moves_d = '0;
        gs_d = 1'b1;
        st_d = FIRST;
      end
      FIRST: if (legal) begin
        face_d[sel_idx] = 1'b1;
        a_d = sel_idx;
        st_d = SECOND;
      end
      SECOND: if (legal) begin
        face_d[sel_idx] = 1'b1;
        b_d = sel_idx;
        st_d = COMPARE;
      end
      COMPARE: begin
        moves_d = moves == 8'hff ? moves : moves + 8'd1;
        if (vals[idx_a] == vals[idx_b]) begin
          matched_d[idx_a] = 1'b1;
          matched_d[idx_b] = 1'b1;
          pairs_d = pairs_found + 4'd1;
          ge_d = pairs_found == 4'(N_PAIRS - 1);
          st_d = ge_d ? DONE : FIRST;
        end else begin
          load = 1'b1;
          st_d = SHOW_MISS;
        end
      end
      SHOW_MISS: if (zero) begin
        face_d[idx_a] = 1'b0;
        face_d[idx_b] = 1'b0;
        st_d = FIRST;
      end
      default: st_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      st <= IDLE;
      vals <= '0;
      idx_a <= '0;
      idx_b <= '0;
      face_up <= '0;
      matched <= '0;
      pairs_found <= '0;
      moves <= '0;
      game_start <= 1'b0;
      game_end <= 1'b0;
    end else begin
      st <= st_d;
      vals <= vals_d;
      idx_a <= a_d;
      idx_b <= b_d;
      face_up <= face_d;
      matched <= matched_d;
      pairs_found <= pairs_d;
      moves <= moves_d;
      game_start <= gs_d;
      game_end <= ge_d;
    end
endmodule

// File: tb/tb_card_flip_ctrl.sv
// tb_card_flip_ctrl: directed self-checking bench for card_flip_ctrl with HOLD_CYCLES=4
module tb_card_flip_ctrl;
  logic clk, reset, start, sel_valid, game_start, game_end;
  logic [47:0] layout;
  logic [3:0] sel_idx, pairs_found;
  logic [15:0] face_up, matched;
  logic [7:0] moves;
  logic [2:0] state;
  int n_checks = 0;
  int n_fail = 0;
  card_flip_ctrl #(.HOLD_CYCLES(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .layout     (layout),
    .sel_valid  (sel_valid),
    .sel_idx    (sel_idx),
    .game_start (game_start),
    .game_end   (game_end),
    .face_up    (face_up),
    .matched    (matched),
    .pairs_found(pairs_found),
    .moves      (moves),
    .state      (state)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic sel(input logic [3:0] idx);
    sel_valid = 1'b1;
    sel_idx = idx;
    tick();
    sel_valid = 1'b0;
  endtask
  initial begin
    reset = 1'b1;
    start = 1'b0;
    sel_valid = 1'b0;
    sel_idx = '0;
    for (int i = 0; i < 16; i++) layout[3*i +: 3] = 3'(i % 8);
    tick();
    tick();
    check("rst_state", state, 0);
    check("rst_face", face_up, 0);
    check("rst_matched", matched, 0);
    check("rst_pairs", pairs_found, 0);
    check("rst_moves", moves, 0);
    check("rst_gs", game_start, 0);
    check("rst_ge", game_end, 0);
    reset = 1'b0;
    tick();
    sel(4'd2);
    check("idle_sel_face", face_up, 0);
    check("idle_sel_state", state, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_gs", game_start, 1);
    check("start_state", state, 1);
    check("start_face", face_up, 0);
    check("start_matched", matched, 0);
    tick();
    check("gs_one_cycle", game_start, 0);
    sel(4'd0);
    check("first_face", face_up, 16'h0001);
    check("first_state", state, 2);
    sel(4'd8);
    check("cmp_state", state, 3);
    check("cmp_matched_pre", matched, 0);
    tick();
    check("hit_matched", matched, 16'h0101);
    check("hit_face", face_up, 16'h0101);
    check("hit_pairs", pairs_found, 1);
    check("hit_moves", moves, 1);
    check("hit_state", state, 1);
    sel(4'd1);
    sel(4'd2);
    check("miss_cmp_state", state, 3);
    check("miss_face_cmp", face_up, 16'h0107);
    tick();
    check("miss_state", state, 4);
    check("miss_moves", moves, 2);
    sel(4'd5);
    check("hold_sel_face", face_up, 16'h0107);
    tick();
    tick();
    check("hold_face_late", face_up, 16'h0107);
    check("hold_state_late", state, 4);
    tick();
    check("miss_clear_face", face_up, 16'h0101);
    check("miss_clear_state", state, 1);
    sel(4'd0);
    check("pick_matched_state", state, 1);
    check("pick_matched_face", face_up, 16'h0101);
    sel(4'd3);
    sel(4'd3);
    check("repick_state", state, 2);
    check("repick_face", face_up, 16'h0109);
    sel(4'd11);
    tick();
    check("pair3_matched", matched, 16'h0909);
    check("pair3_pairs", pairs_found, 2);
    check("pair3_moves", moves, 3);
    for (int p = 1; p < 7; p++) begin
      if (p == 3) continue;
      sel(4'(p));
      sel(4'(p + 8));
      tick();
    end
    check("pre_last_pairs", pairs_found, 7);
    sel(4'd7);
    sel(4'd15);
    check("last_cmp_ge", game_end, 0);
    tick();
    check("end_ge", game_end, 1);
    check("end_gs", game_start, 0);
    check("end_state", state, 5);
    check("end_matched", matched, 16'hffff);
    check("end_face", face_up, 16'hffff);
    check("end_pairs", pairs_found, 8);
    check("end_moves", moves, 9);
    tick();
    check("ge_one_cycle", game_end, 0);
    check("done_hold_state", state, 5);
    check("done_hold_pairs", pairs_found, 8);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_gs", game_start, 1);
    check("restart_face", face_up, 0);
    check("restart_matched", matched, 0);
    check("restart_moves", moves, 0);
    check("restart_pairs", pairs_found, 0);
    check("restart_state", state, 1);
    sel(4'd0);
    sel(4'd1);
    tick();
    check("pre_rst_state", state, 4);
    #2 reset = 1'b1;
    #1;
    check("arst_state", state, 0);
    check("arst_face", face_up, 0);
    check("arst_moves", moves, 0);
    check("arst_matched", matched, 0);
    reset = 1'b0;
    tick();
    sel(4'd4);
    check("post_rst_face", face_up, 0);
    check("post_rst_state", state, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
